// File: rtl/apb_gpio_debounce_pkg.sv
// Shared definitions for the GPIO input-conditioning block: register
// word indices (PADDR[4:2]) and the index type used by the decoder.
package apb_gpio_debounce_pkg;

    typedef logic [2:0] db_reg_idx_t;

    localparam db_reg_idx_t DB_REG_DBEN    = 3'd0;  // 0x00 per-pin debounce enable
    localparam db_reg_idx_t DB_REG_PRESC   = 3'd1;  // 0x04 prescaler divide value
    localparam db_reg_idx_t DB_REG_THRESH  = 3'd2;  // 0x08 stable ticks required
    localparam db_reg_idx_t DB_REG_RAW     = 3'd3;  // 0x0C synchronised pads (RO)
    localparam db_reg_idx_t DB_REG_FILT    = 3'd4;  // 0x10 filtered level (RO)
    localparam db_reg_idx_t DB_REG_CHANGED = 3'd5;  // 0x14 sticky toggle flags (W1C)

endpackage

// File: rtl/gpio_debounce_cell.sv
// One pin of the conditioning stage: two-flop synchroniser, stability
// counter advanced on the shared prescaler tick, filtered level and a
// one-cycle toggle pulse that trails the filtered edge by one clock.
module gpio_debounce_cell
    import apb_gpio_debounce_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 pad,
    input  logic                 tick,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] thresh,
    output logic                 raw,
    output logic                 filt,
    output logic                 filt_event
);
    localparam logic [CNT_WIDTH:0] CNT_ONE = {{CNT_WIDTH{1'b0}}, 1'b1};

    logic                 sync0_reg;
    logic                 sync1_reg;
    logic                 filt_reg;
    logic                 filt_next;
    logic                 filt_d_reg;
    logic                 event_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [CNT_WIDTH:0]   cnt_inc;
    logic [CNT_WIDTH:0]   thresh_eff;

    // One extra bit so cnt+1 never wraps before the compare; THRESH=0 acts as 1.
    assign cnt_inc    = {1'b0, cnt_reg} + CNT_ONE;
    assign thresh_eff = (thresh == '0) ? CNT_ONE : {1'b0, thresh};

    // Next filtered level and stability count.
    always_comb begin
        filt_next = filt_reg;
        cnt_next  = cnt_reg;
        if (!en) begin
            filt_next = sync1_reg;
            cnt_next  = '0;
        end else if (sync1_reg == filt_reg) begin
            cnt_next = '0;
        end else if (tick) begin
            if (cnt_inc >= thresh_eff) begin
                filt_next = sync1_reg;
                cnt_next  = '0;
            end else if (cnt_reg != '1) begin
                cnt_next = cnt_inc[CNT_WIDTH-1:0];
            end
        end
    end

    // Synchroniser, filter state and toggle pulse.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync0_reg  <= 1'b0;
            sync1_reg  <= 1'b0;
            filt_reg   <= 1'b0;
            filt_d_reg <= 1'b0;
            event_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync0_reg  <= pad;
            sync1_reg  <= sync0_reg;
            filt_reg   <= filt_next;
            filt_d_reg <= filt_reg;
            event_reg  <= filt_reg ^ filt_d_reg;
            cnt_reg    <= cnt_next;
        end
    end

    assign raw        = sync1_reg;
    assign filt       = filt_reg;
    assign filt_event = event_reg;

endmodule

// File: rtl/apb_gpio_debounce.sv
// APB-programmable input conditioning ahead of apb_gpio: register file,
// shared prescaler tick, sticky CHANGED flags and one cell per pin.
module apb_gpio_debounce
    import apb_gpio_debounce_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int N_GPIO         = 32,
    parameter int CNT_WIDTH      = 8,
    parameter int PRESC_WIDTH    = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [N_GPIO-1:0]         pad_in,
    output logic [N_GPIO-1:0]         gpio_filt,
    output logic [N_GPIO-1:0]         filt_event
);
    localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = {{(PRESC_WIDTH-1){1'b0}}, 1'b1};

    logic [N_GPIO-1:0]      dben_reg;
    logic [PRESC_WIDTH-1:0] presc_reg;
    logic [CNT_WIDTH-1:0]   thresh_reg;
    logic [N_GPIO-1:0]      changed_reg;
    logic [N_GPIO-1:0]      changed_clr;
    logic [PRESC_WIDTH-1:0] presc_cnt_reg;
    logic [N_GPIO-1:0]      raw_w;
    logic [N_GPIO-1:0]      filt_w;
    logic [N_GPIO-1:0]      event_w;
    logic                   tick;
    logic                   apb_wr;
    logic                   presc_wr;
    logic                   apb_unused;
    db_reg_idx_t            reg_idx;

    assign reg_idx     = PADDR[4:2];
    assign apb_wr      = PSEL & PENABLE & PWRITE;
    assign presc_wr    = apb_wr && (reg_idx == DB_REG_PRESC);
    assign changed_clr = (apb_wr && (reg_idx == DB_REG_CHANGED)) ? PWDATA[N_GPIO-1:0] : '0;
    assign tick        = (presc_cnt_reg == presc_reg);
    assign PREADY      = 1'b1;
    assign PSLVERR     = 1'b0;
    // Address bits outside [4:2] and data bits above each field are don't-care.
    assign apb_unused  = ^{PADDR, PWDATA};

    // Writable configuration registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dben_reg   <= '0;
            presc_reg  <= '0;
            thresh_reg <= '0;
        end else if (apb_wr) begin
            case (reg_idx)
                DB_REG_DBEN:   dben_reg   <= PWDATA[N_GPIO-1:0];
                DB_REG_PRESC:  presc_reg  <= PWDATA[PRESC_WIDTH-1:0];
                DB_REG_THRESH: thresh_reg <= PWDATA[CNT_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Sticky toggle flags; a new event in the clearing cycle keeps the bit set.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            changed_reg <= '0;
        end else begin
            changed_reg <= (changed_reg & ~changed_clr) | event_w;
        end
    end

    // Prescaler counts 0..PRESC; restarting it on a PRESC write gives a clean phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            presc_cnt_reg <= '0;
        end else if (presc_wr || tick) begin
            presc_cnt_reg <= '0;
        end else begin
            presc_cnt_reg <= presc_cnt_reg + PRESC_ONE;
        end
    end

    // Zero-wait-state read mux driven by the address alone.
    always_comb begin
        PRDATA = '0;
        case (reg_idx)
            DB_REG_DBEN:    PRDATA = 32'(dben_reg);
            DB_REG_PRESC:   PRDATA = 32'(presc_reg);
            DB_REG_THRESH:  PRDATA = 32'(thresh_reg);
            DB_REG_RAW:     PRDATA = 32'(raw_w);
            DB_REG_FILT:    PRDATA = 32'(filt_w);
            DB_REG_CHANGED: PRDATA = 32'(changed_reg);
            default:        PRDATA = '0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_GPIO; gi++) begin : g_cell
            gpio_debounce_cell #(
                .CNT_WIDTH(CNT_WIDTH)
            ) u_cell (
                .HCLK      (HCLK),
                .HRESET    (HRESET),
                .pad       (pad_in[gi]),
                .tick      (tick),
                .en        (dben_reg[gi]),
                .thresh    (thresh_reg),
                .raw       (raw_w[gi]),
                .filt      (filt_w[gi]),
                .filt_event(event_w[gi])
            );
        end
    endgenerate

    assign gpio_filt  = filt_w;
    assign filt_event = event_w;

endmodule

// File: tb/tb_apb_gpio_debounce.sv
// Self-checking bench for apb_gpio_debounce: a timestamp-based reference
// model feeds a scoreboard; directed scenarios plus randomized traffic.
module tb_apb_gpio_debounce;

    typedef struct packed {
        logic [31:0] filt;
        logic [31:0] ev;
    } out_exp_t;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] pad_in = '0;
    logic [31:0] gpio_filt;
    logic [31:0] filt_event;

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_done = 0;

    out_exp_t    exp_q[$];
    logic [31:0] rd_q[$];

    // Reference model state: values visible after the most recent edge.
    logic [31:0] m_sync0 = '0, m_sync1 = '0, m_filt = '0, m_event = '0;
    logic [31:0] m_toggled = '0, m_changed = '0, m_dben = '0;
    int m_presc = 0, m_thresh = 0;
    int edge_no = 0, restart_edge = 0, ticks_total = 0;
    bit in_run[32];
    int run_mark[32];

    apb_gpio_debounce dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .pad_in    (pad_in),
        .gpio_filt (gpio_filt),
        .filt_event(filt_event)
    );

    always #5 HCLK = ~HCLK;

    // Reference model. A tick is due when the number of edges since the
    // prescaler last restarted, taken modulo PRESC+1, reaches PRESC. A pin
    // whose synchronised level disagrees with its filtered level adopts it
    // once the ticks counted since the disagreement began reach max(THRESH,1).
    always @(posedge HCLK) begin : ref_model
        logic [31:0] filt_now;
        logic [31:0] clr;
        bit          tk;
        bit          wr;
        logic [2:0]  idx;
        int          base;
        int          t_req;
        edge_no++;
        if (HRESET) begin
            m_sync0 = '0; m_sync1 = '0; m_filt = '0; m_event = '0;
            m_toggled = '0; m_changed = '0; m_dben = '0;
            m_presc = 0; m_thresh = 0;
            restart_edge = edge_no + 1;
            for (int i = 0; i < 32; i++) in_run[i] = 0;
        end else begin
            wr    = PSEL && PENABLE && PWRITE;
            idx   = PADDR[4:2];
            tk    = ((edge_no - restart_edge) % (m_presc + 1)) == m_presc;
            base  = ticks_total;
            if (tk) ticks_total++;
            t_req = (m_thresh == 0) ? 1 : m_thresh;
            filt_now = m_filt;
            for (int i = 0; i < 32; i++) begin
                if (!m_dben[i]) begin
                    filt_now[i] = m_sync1[i];
                    in_run[i]   = 0;
                end else if (m_sync1[i] == m_filt[i]) begin
                    in_run[i] = 0;
                end else begin
                    if (!in_run[i]) begin
                        in_run[i]   = 1;
                        run_mark[i] = base;
                    end
                    if (tk && (ticks_total - run_mark[i]) >= t_req) begin
                        filt_now[i] = m_sync1[i];
                        in_run[i]   = 0;
                    end
                end
            end
            clr       = (wr && idx == 3'd5) ? PWDATA : 32'h0;
            m_changed = (m_changed & ~clr) | m_event;
            m_event   = m_toggled;
            m_toggled = filt_now ^ m_filt;
            m_filt    = filt_now;
            m_sync1   = m_sync0;
            m_sync0   = pad_in;
            if (wr) begin
                case (idx)
                    3'd0: m_dben = PWDATA;
                    3'd1: begin
                        m_presc      = int'(PWDATA[15:0]);
                        restart_edge = edge_no + 1;
                    end
                    3'd2: m_thresh = int'(PWDATA[7:0]);
                    default: ;
                endcase
            end
        end
        exp_q.push_back('{filt: m_filt, ev: m_event});
    end

    function automatic logic [31:0] model_read(input logic [2:0] idx);
        case (idx)
            3'd0:    return m_dben;
            3'd1:    return 32'(m_presc);
            3'd2:    return 32'(m_thresh);
            3'd3:    return m_sync1;
            3'd4:    return m_filt;
            3'd5:    return m_changed;
            default: return 32'h0;
        endcase
    endfunction

    // Monitor: compares outputs every cycle and read data whenever an access phase is seen.
    always @(negedge HCLK) begin : monitor
        out_exp_t    e;
        logic [31:0] rexp;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (gpio_filt !== e.filt) begin
                n_fail++;
                $display("FAIL gpio_filt @%0t: got=%h expected=%h", $time, gpio_filt, e.filt);
            end
            n_checks++;
            if (filt_event !== e.ev) begin
                n_fail++;
                $display("FAIL filt_event @%0t: got=%h expected=%h", $time, filt_event, e.ev);
            end
        end
        if (PSEL && PENABLE && !PWRITE) begin
            n_checks++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected @%0t: got=%h expected=none", $time, PRDATA);
            end else begin
                rexp = rd_q.pop_front();
                $display("rd idx=%0d data=%h exp=%h", PADDR[4:2], PRDATA, rexp);
                if (PRDATA !== rexp) begin
                    n_fail++;
                    $display("FAIL prdata idx=%0d: got=%h expected=%h", PADDR[4:2], PRDATA, rexp);
                end
            end
            n_checks++;
            if (PREADY !== 1'b1 || PSLVERR !== 1'b0) begin
                n_fail++;
                $display("FAIL apb_resp: got ready=%b slverr=%b expected ready=1 slverr=0", PREADY, PSLVERR);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [2:0] idx, input logic [31:0] data);
        logic [11:0] a;
        a       = 12'($urandom);
        a[4:2]  = idx;
        PADDR   = a;
        PWDATA  = data;
        PWRITE  = 1'b1;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        step(1);
        PENABLE = 1'b1;
        step(1);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        $display("wr idx=%0d data=%h", idx, data);
    endtask

    task automatic apb_read(input logic [2:0] idx, output logic [31:0] data);
        logic [11:0] a;
        a       = 12'($urandom);
        a[4:2]  = idx;
        PADDR   = a;
        PWRITE  = 1'b0;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        step(1);
        PENABLE = 1'b1;
        rd_q.push_back(model_read(idx));
        @(negedge HCLK);
        data = PRDATA;
        @(posedge HCLK);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    initial begin : stim
        logic [31:0] rd;
        logic [31:0] acc;
        int          lat;
        int          r;
        logic [2:0]  idx;
        logic [31:0] d;

        // Reset state
        step(3);
        check("reset_filt", gpio_filt, 32'h0);
        check("reset_event", filt_event, 32'h0);

        // Bypass: three-edge latency
        HRESET = 1'b0;
        pad_in = 32'h5;
        step(2);
        check("bypass_edge2", gpio_filt, 32'h0);
        step(1);
        check("bypass_edge3", gpio_filt, 32'h5);
        apb_read(3'd3, rd); check("raw_read", rd, 32'h5);
        apb_read(3'd4, rd); check("filt_read", rd, 32'h5);
        step(1);
        apb_read(3'd5, rd); check("changed_bypass", rd, 32'h5);
        apb_read(3'd1, rd); check("presc_reset", rd, 32'h0);

        // Debounce, PRESC=0, THRESH=4: pin0 rises at edge 6, pulses at edge 7
        pad_in = 32'h0;
        step(4);
        apb_write(3'd0, 32'hFFFF_FFFF);
        apb_write(3'd1, 32'h0);
        apb_write(3'd2, 32'h4);
        apb_write(3'd5, 32'hFFFF_FFFF);
        pad_in = 32'h1;
        step(5);
        check("deb_edge5", gpio_filt & 32'h1, 32'h0);
        step(1);
        check("deb_edge6", gpio_filt & 32'h1, 32'h1);
        check("deb_ev_edge6", filt_event & 32'h1, 32'h0);
        step(1);
        check("deb_ev_edge7", filt_event & 32'h1, 32'h1);
        step(1);
        check("deb_ev_edge8", filt_event & 32'h1, 32'h0);

        // Glitch of three cycles on pin1 is rejected
        pad_in = 32'h3;
        acc = '0;
        repeat (3) begin step(1); acc |= (filt_event | gpio_filt) & 32'h2; end
        pad_in = 32'h1;
        repeat (8) begin step(1); acc |= (filt_event | gpio_filt) & 32'h2; end
        check("glitch_reject", acc, 32'h0);
        apb_read(3'd5, rd); check("glitch_changed", rd & 32'h2, 32'h0);

        // PRESC=9, THRESH=2: pin2 toggles 13..22 edges after the pad change
        apb_write(3'd1, 32'd9);
        apb_write(3'd2, 32'd2);
        pad_in = 32'h5;
        lat = 0;
        for (int k = 1; k <= 25; k++) begin
            step(1);
            if (gpio_filt[2] && lat == 0) lat = k;
        end
        n_checks++;
        if (lat < 13 || lat > 22) begin
            n_fail++;
            $display("FAIL presc9_latency: got=%0d expected=13..22", lat);
        end
        // PRESC rewritten to 0 mid-count: resolves within two further edges
        pad_in = 32'h1;
        step(8);
        apb_write(3'd1, 32'h0);
        step(2);
        check("presc_restart", gpio_filt & 32'h4, 32'h0);

        // CHANGED: set, set-wins against a simultaneous clear, then W1C
        apb_write(3'd0, 32'h0);
        step(4);
        apb_write(3'd5, 32'hFFFF_FFFF);
        apb_read(3'd5, rd); check("changed_clear", rd, 32'h0);
        pad_in = 32'h0;
        step(6);
        apb_read(3'd5, rd); check("changed_set", rd, 32'h1);
        pad_in = 32'h1;
        step(3);
        apb_write(3'd5, 32'h1);
        apb_read(3'd5, rd); check("changed_set_wins", rd, 32'h1);
        apb_write(3'd5, 32'h1);
        apb_read(3'd5, rd); check("changed_w1c", rd, 32'h0);

        // Reset in the middle of a count; pad reappears through bypass
        apb_write(3'd0, 32'hFFFF_FFFF);
        apb_write(3'd2, 32'd5);
        pad_in = 32'h9;
        step(5);
        HRESET = 1'b1;
        step(1);
        check("midreset_filt", gpio_filt, 32'h0);
        check("midreset_event", filt_event, 32'h0);
        HRESET = 1'b0;
        step(2);
        check("postreset_edge2", gpio_filt & 32'h8, 32'h0);
        step(1);
        check("postreset_edge3", gpio_filt & 32'h8, 32'h8);

        // Randomized traffic against the reference model
        fork
            begin : pad_drv
                while (!rand_done) begin
                    @(posedge HCLK);
                    #1;
                    pad_in ^= ($urandom & $urandom & $urandom & $urandom & $urandom);
                end
            end
            begin : apb_drv
                for (int op = 0; op < 400; op++) begin
                    r = $urandom_range(0, 99);
                    if (r < 2) begin
                        HRESET = 1'b1;
                        step($urandom_range(1, 2));
                        HRESET = 1'b0;
                    end else if (r < 22) begin
                        idx = 3'($urandom_range(0, 7));
                        case (idx)
                            3'd0:    d = $urandom | $urandom;
                            3'd1:    d = 32'($urandom_range(0, 3)) | ($urandom << 16);
                            3'd2:    d = 32'($urandom_range(0, 5)) | ($urandom << 8);
                            default: d = $urandom;
                        endcase
                        apb_write(idx, d);
                    end else if (r < 60) begin
                        apb_read(3'($urandom_range(0, 7)), rd);
                    end else begin
                        step($urandom_range(1, 6));
                    end
                end
                rand_done = 1;
            end
        join

        step(3);
        check("read_queue_drained", 32'(rd_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
